// File: rtl/async_rx_pkg.sv
// Shared types for the oversampled asynchronous receiver: parity modes,
// receive FSM states and the buffered word format.
package async_rx_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_mode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     perr;
    logic                     ferr;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Received-word buffer with registered head outputs; a push becomes visible
// at the head one cycle after it is written (no bypass path).
module rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_valid_q, ovf_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             full, pop, wr_ok;

  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop    = rd_valid_q && rd_ready_i;
  assign wr_ok  = wr_en_i && (!full || pop);
  assign wptr_d = wptr_q + PW'(wr_ok);
  assign rptr_d = rptr_q + PW'(pop);

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  // Head registers look at the pre-push write pointer, so a fresh word lands one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= (wptr_q != rptr_d);
      rd_data_q  <= mem_q[rptr_d[AW-1:0]];
      ovf_q      <= wr_en_i && full && !pop;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/async_receiver_cfg.sv
// Configurable oversampling UART receiver: synchroniser, majority-vote bit
// FSM with parity/framing/break detection, feeding an rx_fifo.
module async_receiver_cfg
  import async_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_uart,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_perr,
  output logic                 out_ferr,
  output logic                 break_det,
  output logic                 overflow
);

  localparam int              PW      = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0]   PH_S0   = PW'(OVERSAMPLE/2 - 1);
  localparam logic [PW-1:0]   PH_S1   = PW'(OVERSAMPLE/2);
  localparam logic [PW-1:0]   PH_DEC  = PW'(OVERSAMPLE/2 + 1);
  localparam logic [PW-1:0]   PH_LAST = PW'(OVERSAMPLE - 1);
  localparam par_mode_e       PMODE   = par_mode_e'(PARITY);
  localparam int              SHR     = MAX_DATA_BITS - DATA_BITS;

  rx_state_e                state_q, state_d;
  logic                     rx_meta_q, rx_s_q;
  logic [PW-1:0]            phase_q, phase_d;
  logic [3:0]               bitcnt_q, bitcnt_d;
  logic                     stopcnt_q, stopcnt_d;
  logic                     perr_q, perr_d, parbit_q, parbit_d, ferr_q, ferr_d;
  logic                     first_low_q, first_low_d, wait_long_q, wait_long_d;
  logic                     brk_q, brk_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d, data_w;
  logic                     s0_q, s0_d, s1_q, s1_d;
  logic                     start_cond, wrap, decide, bit_v, stop_final, ferr_now, is_break, push;
  rx_entry_t                wr_entry, head;

  // rx_meta_q is the value rx_s takes next edge, so the falling edge lines phase 0 up with the first low rx_s cycle.
  assign start_cond = rx_s_q && !rx_meta_q;
  assign wrap       = (phase_q == PH_LAST);
  assign decide     = (phase_q == PH_DEC);
  assign bit_v      = maj3(s0_q, s1_q, rx_s_q);
  assign data_w     = shift_q >> SHR;
  assign stop_final = (stopcnt_q == 1'(STOP_BITS - 1));
  assign s0_d       = (phase_q == PH_S0) ? rx_s_q : s0_q;
  assign s1_d       = (phase_q == PH_S1) ? rx_s_q : s1_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bitcnt_d      = bitcnt_q;
    stopcnt_d     = stopcnt_q;
    perr_d        = perr_q;
    parbit_d      = parbit_q;
    ferr_d        = ferr_q;
    first_low_d   = first_low_q;
    wait_long_d   = wait_long_q;
    shift_d       = shift_q;
    brk_d         = 1'b0;
    push          = 1'b0;
    ferr_now      = ferr_q | ~bit_v;
    is_break      = (data_w == '0) && ((PMODE == PAR_NONE) || !parbit_q) &&
                    ((stopcnt_q == 1'b0) ? ~bit_v : first_low_q);
    wr_entry.data = data_w;
    wr_entry.perr = perr_q;
    wr_entry.ferr = ferr_now;
    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
      phase_d = wrap ? '0 : phase_q + PW'(1);
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (start_cond) state_d = S_START;
      end
      S_START: begin
        if (wrap) state_d = S_DATA;
        if (decide) begin
          if (bit_v) state_d = S_IDLE;
          bitcnt_d    = '0;
          stopcnt_d   = 1'b0;
          perr_d      = 1'b0;
          parbit_d    = 1'b0;
          ferr_d      = 1'b0;
          first_low_d = 1'b0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {bit_v, shift_q[MAX_DATA_BITS-1:1]};
        if (wrap) begin
          if (bitcnt_q == 4'(DATA_BITS - 1))
            state_d = (PMODE == PAR_NONE) ? S_STOP : S_PARITY;
          else
            bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (decide) begin
          parbit_d = bit_v;
          perr_d   = (PMODE == PAR_EVEN) ? (^data_w ^ bit_v) : ~(^data_w ^ bit_v);
        end
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (wrap && !stop_final) stopcnt_d = 1'b1;
        if (decide) begin
          if (stopcnt_q == 1'b0) first_low_d = ~bit_v;
          if (stop_final) begin
            push    = 1'b1;
            phase_d = '0;
            if (is_break) begin
              state_d     = S_WAIT_IDLE;
              wait_long_d = 1'b1;
              brk_d       = 1'b1;
            end else if (ferr_now) begin
              state_d     = S_WAIT_IDLE;
              wait_long_d = 1'b0;
            end else begin
              // With short bit times the next start edge can already be arriving here.
              state_d = start_cond ? S_START : S_IDLE;
            end
          end else begin
            ferr_d = ferr_now;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (wait_long_q) begin
          if (!rx_s_q)   phase_d = '0;
          else if (wrap) state_d = S_IDLE;
          else           phase_d = phase_q + PW'(1);
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      phase_q     <= '0;
      bitcnt_q    <= '0;
      stopcnt_q   <= 1'b0;
      perr_q      <= 1'b0;
      parbit_q    <= 1'b0;
      ferr_q      <= 1'b0;
      first_low_q <= 1'b0;
      wait_long_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      stopcnt_q   <= stopcnt_d;
      perr_q      <= perr_d;
      parbit_q    <= parbit_d;
      ferr_q      <= ferr_d;
      first_low_q <= first_low_d;
      wait_long_q <= wait_long_d;
      brk_q       <= brk_d;
    end
  end

  always_ff @(posedge clk_uart) begin
    shift_q <= shift_d;
    s0_q    <= s0_d;
    s1_q    <= s1_d;
  end

  rx_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_uart),
    .rst_ni    (rst_n),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_valid_o(out_valid),
    .rd_ready_i(out_ready),
    .rd_data_o (head),
    .overflow_o(overflow)
  );

  assign out_data  = DATA_BITS'(head.data);
  assign out_perr  = head.perr;
  assign out_ferr  = head.ferr;
  assign break_det = brk_q;

endmodule

// File: tb/tb_async_receiver_cfg.sv
// Directed bench: default receiver, even-parity receiver and a 9-bit/2-stop
// receiver at OVERSAMPLE=4, each fed hand-built serial frames.
module tb_async_receiver_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] rx, rdy;
  wire  [2:0] vld, perr, ferr, brk, ovf;
  wire  [7:0] data0, data1;
  wire  [8:0] data2;

  int vectors = 0, miscompares = 0;
  int brk0 = 0, ovf0 = 0;
  logic [10:0] q0[$], q1[$], q2[$];

  async_receiver_cfg dut0 (
    .clk_uart(clk), .rst_n(rst_n), .rx(rx[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
    .out_data(data0), .out_perr(perr[0]), .out_ferr(ferr[0]), .break_det(brk[0]), .overflow(ovf[0]));

  async_receiver_cfg #(.PARITY(1)) dut1 (
    .clk_uart(clk), .rst_n(rst_n), .rx(rx[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
    .out_data(data1), .out_perr(perr[1]), .out_ferr(ferr[1]), .break_det(brk[1]), .overflow(ovf[1]));

  async_receiver_cfg #(.OVERSAMPLE(4), .DATA_BITS(9), .STOP_BITS(2)) dut2 (
    .clk_uart(clk), .rst_n(rst_n), .rx(rx[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
    .out_data(data2), .out_perr(perr[2]), .out_ferr(ferr[2]), .break_det(brk[2]), .overflow(ovf[2]));

  // Record every accepted word as {perr, ferr, data}.
  always @(negedge clk) begin
    if (vld[0] && rdy[0]) q0.push_back({perr[0], ferr[0], 1'b0, data0});
    if (vld[1] && rdy[1]) q1.push_back({perr[1], ferr[1], 1'b0, data1});
    if (vld[2] && rdy[2]) q2.push_back({perr[2], ferr[2], data2});
    if (brk[0]) brk0++;
    if (ovf[0]) ovf0++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [10:0] qpop(input int idx);
    case (idx)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int idx, input int os, input logic b);
    rx[idx] = b;
    repeat (os) @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send(input int idx, input int os, input int nbits, input logic [8:0] val,
                      input int par, input int nstop);
    drive_bit(idx, os, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(idx, os, val[i]);
    if (par >= 0) drive_bit(idx, os, par[0]);
    for (int i = 0; i < nstop; i++) drive_bit(idx, os, 1'b1);
  endtask

  task automatic expect_word(input int idx, input string tag, input logic [10:0] exp);
    logic [10:0] w;
    int n;
    n = 0;
    while (qsize(idx) == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (qsize(idx) == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      w = qpop(idx);
      chk(tag, {21'd0, w}, {21'd0, exp});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq4 [4];
    int b0, o0;
    seq4 = '{8'h55, 8'h34, 8'hAF, 8'h00};
    rst_n = 1'b0;
    rx    = 3'b111;
    rdy   = 3'b111;
    repeat (4) @(negedge clk);
    chk("rst_valid", {29'd0, vld}, 32'd0);
    chk("rst_data0", {24'd0, data0}, 32'd0);
    chk("rst_data2", {23'd0, data2}, 32'd0);
    chk("rst_flags", {20'd0, perr, ferr, brk, ovf}, 32'd0);
    sync();
    rst_n = 1'b1;
    repeat (10) sync();

    // Four back-to-back default frames.
    for (int i = 0; i < 4; i++) send(0, 8, 8, {1'b0, seq4[i]}, -1, 1);
    for (int i = 0; i < 4; i++) expect_word(0, "b2b_word", {3'b000, seq4[i]});
    chk("b2b_no_break", brk0, 0);
    chk("b2b_no_ovf", ovf0, 0);

    // Three-cycle glitch must be rejected, then a real frame still decodes.
    sync();
    rx[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_nopush", q0.size(), 0);
    sync();
    send(0, 8, 8, 9'h0A5, -1, 1);
    expect_word(0, "post_glitch_word", 11'h0A5);

    // Break: 20 bit times low, a short high blip, more low, then idle and a frame.
    sync();
    b0 = brk0;
    rx[0] = 1'b0;
    repeat (160) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    send(0, 8, 8, 9'h03C, -1, 1);
    expect_word(0, "brk_word", {2'b01, 9'h000});
    expect_word(0, "post_brk_word", 11'h03C);
    repeat (20) @(negedge clk);
    chk("brk_pulses", brk0 - b0, 1);
    chk("brk_no_extra", q0.size(), 0);

    // Overflow: six frames into a depth-4 buffer with the consumer stalled.
    sync();
    rdy[0] = 1'b0;
    o0 = ovf0;
    send(0, 8, 8, 9'h011, -1, 1);
    repeat (2) @(negedge clk);
    chk("ovf_valid_first", vld[0], 1);
    chk("ovf_data_first", data0, 8'h11);
    sync();
    send(0, 8, 8, 9'h022, -1, 1);
    send(0, 8, 8, 9'h033, -1, 1);
    send(0, 8, 8, 9'h044, -1, 1);
    send(0, 8, 8, 9'h055, -1, 1);
    send(0, 8, 8, 9'h066, -1, 1);
    repeat (20) @(negedge clk);
    chk("ovf_pulses", ovf0 - o0, 2);
    chk("ovf_no_pop", q0.size(), 0);
    sync();
    rdy[0] = 1'b1;
    expect_word(0, "ovf_drain1", 11'h011);
    expect_word(0, "ovf_drain2", 11'h022);
    expect_word(0, "ovf_drain3", 11'h033);
    expect_word(0, "ovf_drain4", 11'h044);
    repeat (30) @(negedge clk);
    chk("ovf_drained", q0.size(), 0);
    chk("ovf_empty_valid", vld[0], 0);

    // Reset in the middle of a frame, then 0xFF.
    sync();
    rx[0] = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_valid", vld[0], 0);
    sync();
    rst_n = 1'b1;
    repeat (20) sync();
    send(0, 8, 8, 9'h0FF, -1, 1);
    expect_word(0, "midrst_word", 11'h0FF);
    repeat (30) @(negedge clk);
    chk("midrst_only_one", q0.size(), 0);

    // Even parity: 0x17 has four ones, so the correct parity bit is 0.
    sync();
    send(1, 8, 8, 9'h017, 0, 1);
    send(1, 8, 8, 9'h017, 1, 1);
    send(1, 8, 8, 9'h001, 1, 1);
    expect_word(1, "par_good", 11'h017);
    expect_word(1, "par_bad", {2'b10, 9'h017});
    expect_word(1, "par_good_odd_ones", 11'h001);

    // 9-bit, two stop bits, OVERSAMPLE=4: every code back-to-back.
    sync();
    for (int i = 0; i < 512; i++) send(2, 4, 9, 9'(i), -1, 2);
    for (int i = 0; i < 512; i++) expect_word(2, "sweep", {2'b00, 9'(i)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
